// File: rtl/posit_pkg.sv
// Shared posit (es=2) sizing helpers, special-value constants and the
// dot-product FSM state encoding.
package posit_pkg;

  localparam int unsigned P_N  = 8;
  localparam int unsigned P_ES = 2;

  function automatic int unsigned quire_width(input int unsigned n);
    return 16 * n;
  endfunction

  function automatic int unsigned quire_frac(input int unsigned n);
    return 8 * n - 16;
  endfunction

  // log2(maxpos): maxpos = 2^(4N-8), minpos = 2^-(4N-8)
  function automatic int max_scale(input int unsigned n);
    return 4 * int'(n) - 8;
  endfunction

  localparam int unsigned   P_QW     = quire_width(P_N);
  localparam int unsigned   P_QFRAC  = quire_frac(P_N);
  localparam logic [P_N-1:0] P_NAR    = {1'b1, {(P_N-1){1'b0}}};
  localparam logic [P_N-1:0] P_MAXPOS = {1'b0, {(P_N-1){1'b1}}};
  localparam logic [P_N-1:0] P_MINPOS = {{(P_N-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACCUM,
    S_CONV1,
    S_CONV2,
    S_OUT
  } state_e;

endpackage

// File: rtl/posit_dot_accum_mac.sv
// Combinational posit (es=2) multiply-accumulate into a fixed-point quire:
// R = C + A*B, wrapping modulo 2^QW; any NaR input forces a NaR quire.
module PositMAC
  import posit_pkg::*;
#(
  parameter int unsigned N  = P_N,
  parameter int unsigned QW = quire_width(N)
) (
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  input  logic [QW-1:0] C,
  output logic [QW-1:0] R
);

  localparam int unsigned QFRAC = quire_frac(N);
  localparam int unsigned SW    = N - 2;
  localparam int unsigned PW    = 2 * SW;
  localparam int unsigned WW    = QW + 2 * (N - 3);
  localparam logic [N-1:0]  NAR   = {1'b1, {(N-1){1'b0}}};
  localparam logic [QW-1:0] NAR_Q = {1'b1, {(QW-1){1'b0}}};

  // Significand is 1.f with N-3 fraction bits; scale = 4*k + e.
  function automatic void decode(input logic [N-1:0] p, output logic [SW-1:0] sig,
                                 output int scale);
    logic [N-2:0] rem;
    logic [N-2:0] sh;
    int unsigned  m;
    logic         done;
    rem  = p[N-1] ? (N-1)'(-p) : p[N-2:0];
    m    = 0;
    done = 1'b0;
    for (int unsigned i = 0; i < N - 1; i++) begin
      if (!done && rem[N-2-i] == rem[N-2]) m++;
      else done = 1'b1;
    end
    sh    = rem << (m + 1);
    sig   = {1'b1, sh[N-4:0]};
    scale = 4 * (rem[N-2] ? int'(m) - 1 : -int'(m)) + int'(sh[N-2:N-3]);
  endfunction

  logic [SW-1:0] sig_a, sig_b;
  int            scale_a, scale_b;
  logic [PW-1:0] prod;
  logic [WW-1:0] wide;
  logic [QW-1:0] term;

  always_comb begin
    decode(A, sig_a, scale_a);
    decode(B, sig_b, scale_b);
    prod = PW'(sig_a) * PW'(sig_b);
    // Product LSB weight is 2^(scale_a+scale_b-2(N-3)); the extra low bits of
    // wide keep the shift amount non-negative down to minpos*minpos.
    wide = WW'(prod) << (scale_a + scale_b + int'(QFRAC));
    term = QW'(wide >> (2 * (N - 3)));
    if (A[N-1] ^ B[N-1]) term = -term;
    if (A == '0 || B == '0) term = '0;
    R = C + term;
    if (A == NAR || B == NAR || C == NAR_Q) R = NAR_Q;
  end

endmodule

// File: rtl/posit_dot_accum.sv
// Streaming posit dot product: accumulates a*b pairs into a quire, then
// rounds the quire to a posit over two conversion cycles.
module posit_dot_accum
  import posit_pkg::*;
#(
  parameter int unsigned N  = P_N,
  parameter int unsigned QW = quire_width(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_a,
  input  logic [N-1:0]  in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit,
  output logic [QW-1:0] out_quire,
  output logic [15:0]   out_count
);

  localparam int unsigned QFRAC = quire_frac(N);
  localparam int          MAXSC = max_scale(N);
  localparam int unsigned LW    = $clog2(QW);
  localparam logic [N-1:0]  NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0]  MAXPOS = {1'b0, {(N-1){1'b1}}};
  localparam logic [N-1:0]  MINPOS = {{(N-1){1'b0}}, 1'b1};
  localparam logic [QW-1:0] NAR_Q  = {1'b1, {(QW-1){1'b0}}};

  state_e        state_q, state_d;
  logic [QW-1:0] quire_q, quire_d, mac_c, mac_r;
  logic [15:0]   count_q, count_d;
  logic          sign_q, sign_d, nar_q, nar_d;
  logic [QW-1:0] mag_q, mag_d;
  logic [LW-1:0] lead_q, lead_d;
  logic [N-1:0]  out_posit_q, out_posit_d, conv_posit;
  logic [QW-1:0] out_quire_q, out_quire_d;
  logic [15:0]   out_count_q, out_count_d;
  logic          beat;

  PositMAC #(.N(N), .QW(QW)) u_mac (
    .A(in_a),
    .B(in_b),
    .C(mac_c),
    .R(mac_r)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_ACCUM: if (beat) state_d = in_last ? S_CONV1 : S_ACCUM;
      S_CONV1:         state_d = S_CONV2;
      S_CONV2:         state_d = S_OUT;
      S_OUT:           if (out_ready) state_d = S_IDLE;
      default:         state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
    out_valid = (state_q == S_OUT);
  end

  assign beat = in_valid & in_ready;

  always_comb begin
    mac_c       = (state_q == S_ACCUM) ? quire_q : '0;
    quire_d     = quire_q;
    count_d     = count_q;
    sign_d      = sign_q;
    nar_d       = nar_q;
    mag_d       = mag_q;
    lead_d      = lead_q;
    out_posit_d = out_posit_q;
    out_quire_d = out_quire_q;
    out_count_d = out_count_q;
    if (beat) begin
      quire_d = mac_r;
      if (state_q == S_IDLE)        count_d = 16'd1;
      else if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
    end
    if (state_q == S_CONV1) begin
      sign_d      = quire_q[QW-1];
      nar_d       = (quire_q == NAR_Q);
      mag_d       = quire_q[QW-1] ? -quire_q : quire_q;
      lead_d      = '0;
      for (int unsigned i = 0; i < QW; i++) begin
        if (mag_d[i]) lead_d = LW'(i);
      end
      out_quire_d = quire_q;
      out_count_d = count_q;
    end
    if (state_q == S_CONV2) out_posit_d = conv_posit;
  end

  int             scale, k, rlen;
  logic [1:0]     e;
  logic [N-2:0]   regpat, body;
  logic [QW-2:0]  frac;
  logic [N+QW-1:0] y;
  logic           rnd, sticky;
  logic [N-1:0]   pmag;

  // Regime/exponent/fraction are laid out right-aligned, then shifted so the
  // regime starts at the top; what falls below N-1 bits feeds round/sticky.
  always_comb begin
    scale  = int'(lead_q) - int'(QFRAC);
    k      = scale >>> 2;
    e      = 2'(scale);
    frac   = (QW-1)'(mag_q << (QW - 1 - int'(lead_q)));
    regpat = '0;
    if (k >= 0) begin
      rlen = k + 2;
      for (int unsigned i = 1; i < N - 1; i++) begin
        if (int'(i) <= k + 1) regpat[i] = 1'b1;
      end
    end else begin
      rlen      = 1 - k;
      regpat[0] = 1'b1;
    end
    y      = {regpat, e, frac} << (int'(N) - 1 - rlen);
    body   = y[N+QW-1 -: N-1];
    rnd    = y[QW];
    sticky = |y[QW-1:0];
    body   = body + (N-1)'(rnd & (sticky | body[0]));
    pmag   = {1'b0, body};
    if (scale >= MAXSC)      pmag = MAXPOS;
    else if (scale < -MAXSC) pmag = MINPOS;
    conv_posit = sign_q ? -pmag : pmag;
    if (mag_q == '0) conv_posit = '0;
    if (nar_q)       conv_posit = NAR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quire_q     <= '0;
      count_q     <= '0;
      sign_q      <= 1'b0;
      nar_q       <= 1'b0;
      mag_q       <= '0;
      lead_q      <= '0;
      out_posit_q <= '0;
      out_quire_q <= '0;
      out_count_q <= '0;
    end else begin
      quire_q     <= quire_d;
      count_q     <= count_d;
      sign_q      <= sign_d;
      nar_q       <= nar_d;
      mag_q       <= mag_d;
      lead_q      <= lead_d;
      out_posit_q <= out_posit_d;
      out_quire_q <= out_quire_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_posit = out_posit_q;
  assign out_quire = out_quire_q;
  assign out_count = out_count_q;

endmodule

// File: doc/posit_dot_accum.md
POSIT_DOT_ACCUM -- requirements
Module: posit_dot_accum

Interface
REQ-001 SHALL have parameter N, default 8, the posit width in bits (es fixed at 2).
REQ-002 SHALL have parameter QW, default 16*N, the quire width; derived constant QFRAC = 8*N-16 gives the quire fraction bits (48 at N=8).
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operand pair valid.
REQ-007 in_ready  output  1  block accepts a pair this cycle.
REQ-008 in_a, in_b  input  N  posit operands.
REQ-009 in_last  input  1  final pair of the current dot product.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_posit  output  N  rounded posit result.
REQ-013 out_quire  output  QW  raw final quire, two's complement, LSB weight 2^-QFRAC.
REQ-014 out_count  output  16  number of pairs accumulated, saturating at 0xFFFF.

Function
REQ-015 SHALL implement FSM states IDLE, ACCUM, CONV1, CONV2, OUT.
REQ-016 in_ready SHALL be 1 only in IDLE and ACCUM; a beat transfers on in_valid & in_ready.
REQ-017 On a beat in IDLE, quire SHALL be loaded with a*b (accumulated onto zero), count SHALL be set to 1, and the FSM SHALL go to ACCUM, or to CONV1 if in_last.
REQ-018 On a beat in ACCUM, quire SHALL be updated to quire + a*b through the combinational MAC, count SHALL increment (saturating), and the FSM SHALL go to CONV1 if in_last.
REQ-019 CONV1 SHALL register the sign, |quire| and its leading-one position; CONV2 SHALL build the regime, exponent and fraction and round to nearest, ties to even.
REQ-020 Latency: if in_last is accepted at edge t, out_valid SHALL rise after edge t+2 and be observed in cycle t+3.
REQ-021 In OUT, out_valid SHALL be 1, and out_posit, out_quire and out_count SHALL stay stable until out_valid & out_ready, then the FSM SHALL return to IDLE.
REQ-022 A NaR quire (MSB 1, all other bits 0), or any NaR operand (0x80 at N=8), SHALL make the quire NaR sticky for the rest of the dot product; out_posit SHALL then be 1 followed by N-1 zeros.
REQ-023 A zero quire SHALL give out_posit 0.
REQ-024 Saturation: |value| >= maxpos (2^(4N-8)) SHALL give +/-maxpos; a nonzero |value| < minpos SHALL give +/-minpos, never 0.
REQ-025 Quire addition SHALL wrap modulo 2^QW with no overflow flag.
REQ-026 out_posit, out_quire and out_count SHALL be registered outputs.

Reset
REQ-027 rst SHALL force IDLE and clear the quire and count to 0.
REQ-028 rst SHALL set out_valid=0, out_posit=0 and out_quire=0; in_ready SHALL be 1 in the first cycle after reset.
REQ-029 rst in any state, including mid-CONV or mid-OUT, SHALL abandon the operation with no partial output.

Structure
REQ-030 A shared package posit_pkg SHALL hold N/QW/QFRAC derivation, the NaR/maxpos/minpos constants and the FSM state enum.
REQ-031 SHALL instantiate exactly one sub-module, the existing combinational PositMAC (ports A, B, C, R), with C fed from the quire register or zero.
REQ-032 The quire-to-posit rounding SHALL be local RTL across CONV1/CONV2, not a sub-module.

Verification
REQ-033 Pairs (0x40,0x40) last -> out_posit 0x40, out_quire = 1<<48, out_count 1, out_valid 3 cycles after the beat.
REQ-034 Pairs (0x40,0x40), (0x48,0x48 last) -> value 5.0 -> out_posit 0x52, out_count 2.
REQ-035 Pairs (0x40,0x40), (0xC0,0x40 last) -> out_posit 0x00, out_quire 0.
REQ-036 Pairs (0x80,0x40), (0x40,0x40 last) -> out_posit 0x80; pair (0x7F,0x7F last) -> out_posit 0x7F.
REQ-037 Hold out_ready=0 for 5 cycles in OUT -> out_valid stays 1, outputs stable, in_ready stays 0; release -> IDLE next cycle.
REQ-038 Assert rst during CONV1 -> out_valid never rises; the next single pair (0x38,0x40 last) -> out_posit 0x38.
